branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the 5-stage MIPS32 core. Sits alongside the decode stage: it predicts conditional branches (BEQ, BNE, BGTZ, BLEZ, BLTZ/BGEZ and the AL forms) in D so the hazard unit can redirect fetch early. The branch comparator, relocated to execute, produces the actual outcome in E; this block checks it against the carried prediction, flags mispredicts and trains a table of 2-bit saturating counters.

## Interface

Parameters:
- IDX_W, 6: pattern history table index width, giving 2^IDX_W entries.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- pcD  in  32  PC of the instruction in decode.
- branchD  in  1  decode identifies a conditional branch.
- pred_takeD  out  1  prediction for the instruction in D; combinational.
- stallE  in  1  holds the E-stage registers and suppresses table updates.
- flushE  in  1  loads a bubble into the E-stage registers.
- actual_takeE  in  1  comparator result for the instruction in E.
- pred_takeE  out  1  registered prediction carried to E.
- mispredE  out  1  E branch outcome differs from its prediction; combinational.

## Operation

- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken. Predict taken when bit 1 is set.
- Lookup index idxD is pcD[IDX_W+1:2], combined with the GHR when configured. pred_takeD is branchD & pht[idxD][1], so it is 0 whenever branchD is 0.
- E registers are brE, predE (drives pred_takeE) and idxE.
  - stallE=1: hold all three.
  - flushE=1 and stallE=0: clear all three.
  - Neither: capture branchD, pred_takeD and idxD.
- mispredE is brE & (predE ^ actual_takeE).
- Update condition: brE=1 and stallE=0. pht[idxE] moves one step toward actual_takeE and saturates at 00 and 11. No update when brE=0.
- flushE and stallE do not gate the update of the instruction already in E. The update belongs to the resolving instruction.
- Same-index read and write in one cycle: the D lookup sees the pre-update value. There is no bypass.

## Timing

- Reset state, while resetn is low at a rising edge:
  - every counter is set to 01;
  - brE, predE and idxE are set to 0;
  - the GHR is set to 0;
  - pred_takeE, and therefore mispredE, read 0 from the following cycle.
- Reset asserted mid-operation discards in-flight E state and any pending update. No update occurs on the reset edge.
- Prediction latency: 0 cycles, combinational in D.
- Prediction to check: 1 cycle per un-stalled D to E advance.
- An update is written on the edge ending the E cycle. A lookup of that entry sees it from the next cycle.
- Stall for N cycles: exactly one update, on the cycle stallE falls.

## Configuration

- BP_GSHARE_EN defined:
  - an IDX_W-bit global history register exists;
  - idxD = pcD[IDX_W+1:2] ^ GHR;
  - on each update the GHR shifts left and takes actual_takeE in bit 0, in the same cycle as the counter write;
  - the GHR is non-speculative.
- Undefined: bimodal. idxD = pcD[IDX_W+1:2] and there is no GHR.
- The ports are identical in both builds.

## Structure

- Shared package bp_pkg:
  - the counter encoding constants (SNT, WNT, WT, ST);
  - the saturating next-state function;
  - the reset counter value WNT.
- Opcode and REGIMM rt constants stay in the existing defines header. Decode produces branchD from them.
- One sub-module, bp_pht:
  - 2^IDX_W x 2-bit register array;
  - one combinational read port;
  - one synchronous write port with increment/decrement and saturation;
  - synchronous active-low reset to WNT.
- The top level holds the E registers, the optional GHR, the index formation and the mispredict logic.

## Test plan

- Reset then lookup: pcD=0x00400010, branchD=1 -> pred_takeD=0 (entry WNT); with branchD=0 -> pred_takeD=0; pred_takeE=0 and mispredE=0.
- Training: resolve the same branch taken twice -> counter goes 01 to 10 to 11; first resolve mispredE=1, then pred_takeD=1; a third taken leaves it at 11 (saturation).
- Not-taken saturation: from 11, four not-taken resolves -> 10, 01, 00, 00; mispredE=1 on the resolve where predE=1 and actual=0 only.
- Stall/flush: stallE held 3 cycles with brE=1 -> one update only; flushE with stallE=0 -> next cycle pred_takeE=0 and mispredE=0 even when actual_takeE=1.
- Same-index collision: resolve idx 5 taken from 01 while D looks up idx 5 -> pred_takeD=0 that cycle and 1 the next.
- BP_GSHARE_EN: after outcomes T,T,N the GHR is 0b000110; a lookup at pcD=0x18 uses index 0x06^0x06=0; reset returns the GHR to 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encoding and saturating update.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  localparam ctr_t CTR_RESET = WNT;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) begin
      return (c == ST) ? ST : ctr_t'(c + 2'd1);
    end
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

  function automatic logic ctr_taken(input ctr_t c);
    return c >= WT;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_W two-bit saturating counters, one async read, one sync update.
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [IDX_W-1:0] raddr_i,
  output ctr_t             rdata_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic             taken_i
);

  localparam int unsigned Entries = 2 ** IDX_W;

  ctr_t pht_q [Entries];

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        pht_q[i[IDX_W-1:0]] <= CTR_RESET;
      end
    end else if (we_i) begin
      pht_q[waddr_i] <= ctr_next(pht_q[waddr_i], taken_i);
    end
  end

  // No bypass: a same-cycle read of the written entry returns the old value.
  assign rdata_o = pht_q[raddr_i];

endmodule

// File: rtl/branch_predictor.sv
// Decode-stage dynamic branch predictor with execute-stage check and training.
// Define BP_GSHARE_EN to XOR a non-speculative global history register into the index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pcD,
  input  logic        branchD,
  output logic        pred_takeD,
  input  logic        stallE,
  input  logic        flushE,
  input  logic        actual_takeE,
  output logic        pred_takeE,
  output logic        mispredE
);

  logic [IDX_W-1:0] idxD;
  logic [IDX_W-1:0] idxE_q;
  logic             brE_q;
  logic             predE_q;
  logic             upd;
  ctr_t             rd_ctr;

  // Training belongs to the resolving instruction; flushE does not cancel it.
  assign upd = brE_q & ~stallE;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ghr_q <= '0;
    end else if (upd) begin
      ghr_q <= {ghr_q[IDX_W-2:0], actual_takeE};
    end
  end

  assign idxD = pcD[IDX_W+1:2] ^ ghr_q;
`else
  assign idxD = pcD[IDX_W+1:2];
`endif

  logic unused_pc;
  assign unused_pc = ^{pcD[31:IDX_W+2], pcD[1:0]};

  bp_pht #(
    .IDX_W (IDX_W)
  ) u_pht (
    .clk_i    (clk),
    .resetn_i (resetn),
    .raddr_i  (idxD),
    .rdata_o  (rd_ctr),
    .we_i     (upd),
    .waddr_i  (idxE_q),
    .taken_i  (actual_takeE)
  );

  assign pred_takeD = branchD & ctr_taken(rd_ctr);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      brE_q   <= 1'b0;
      predE_q <= 1'b0;
      idxE_q  <= '0;
    end else if (!stallE) begin
      if (flushE) begin
        brE_q   <= 1'b0;
        predE_q <= 1'b0;
        idxE_q  <= '0;
      end else begin
        brE_q   <= branchD;
        predE_q <= pred_takeD;
        idxE_q  <= idxD;
      end
    end
  end

  assign pred_takeE = predE_q;
  assign mispredE   = brE_q & (predE_q ^ actual_takeE);

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (bimodal by default, gshare with BP_GSHARE_EN).
module tb_branch_predictor;

  localparam int unsigned IDX_W = 6;

  localparam logic [31:0] PcA  = 32'h0040_0010;  // idx 4
  localparam logic [31:0] PcB  = 32'h0040_0020;  // idx 8
  localparam logic [31:0] PcC  = 32'h0040_0030;  // idx 12
  localparam logic [31:0] PcI5 = 32'h0040_0014;  // idx 5

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pcD;
  logic        branchD;
  logic        pred_takeD;
  logic        stallE;
  logic        flushE;
  logic        actual_takeE;
  logic        pred_takeE;
  logic        mispredE;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .IDX_W (IDX_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pcD          (pcD),
    .branchD      (branchD),
    .pred_takeD   (pred_takeD),
    .stallE       (stallE),
    .flushE       (flushE),
    .actual_takeE (actual_takeE),
    .pred_takeE   (pred_takeE),
    .mispredE     (mispredE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn       = 1'b0;
    pcD          = 32'h0;
    branchD      = 1'b0;
    stallE       = 1'b0;
    flushE       = 1'b0;
    actual_takeE = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Lookup in D, advance to E, resolve with the given outcome, let the update land.
  task automatic resolve(input logic [31:0] pc, input logic taken, input logic exp_pred,
                         input logic exp_misp, input string tag);
    pcD          = pc;
    branchD      = 1'b1;
    actual_takeE = 1'b0;
    #1;
    check({tag, ".predD"}, {31'b0, pred_takeD}, {31'b0, exp_pred});
    tick();
    branchD      = 1'b0;
    actual_takeE = taken;
    #1;
    check({tag, ".predE"}, {31'b0, pred_takeE}, {31'b0, exp_pred});
    check({tag, ".misp"}, {31'b0, mispredE}, {31'b0, exp_misp});
    tick();
    actual_takeE = 1'b0;
  endtask

  initial begin
    do_reset();
`ifdef BP_GSHARE_EN
    // Outcomes T,T,N: writes idx 0x10, 0x11, 0x13; GHR ends at 6.
    resolve(32'h40, 1'b1, 1'b0, 1'b1, "g1");
    resolve(32'h40, 1'b1, 1'b0, 1'b1, "g2");
    resolve(32'h40, 1'b0, 1'b0, 1'b0, "g3");
    pcD = 32'h18; branchD = 1'b1; #1;
    check("g.pc18", {31'b0, pred_takeD}, 32'd0);
    pcD = 32'h58; #1;  // 0x16 ^ 6 = 0x10, which holds WT
    check("g.ghr", {31'b0, pred_takeD}, 32'd1);
    branchD = 1'b0;
    do_reset();
    resolve(32'h40, 1'b1, 1'b0, 1'b1, "g.rst");
    pcD = 32'h44; branchD = 1'b1; #1;  // 0x11 ^ 1 = 0x10 only if GHR restarted at 0
    check("g.rstghr", {31'b0, pred_takeD}, 32'd1);
    branchD = 1'b0;
`else
    pcD = PcA; branchD = 1'b1; #1;
    check("reset.predD", {31'b0, pred_takeD}, 32'd0);
    check("reset.predE", {31'b0, pred_takeE}, 32'd0);
    check("reset.misp", {31'b0, mispredE}, 32'd0);
    branchD = 1'b0; actual_takeE = 1'b1; #1;
    check("nobr.predD", {31'b0, pred_takeD}, 32'd0);
    check("nobr.misp", {31'b0, mispredE}, 32'd0);
    actual_takeE = 1'b0;

    resolve(PcA, 1'b1, 1'b0, 1'b1, "t1");  // 01 -> 10
    resolve(PcA, 1'b1, 1'b1, 1'b0, "t2");  // 10 -> 11
    resolve(PcA, 1'b1, 1'b1, 1'b0, "t3");  // 11 -> 11
    resolve(PcA, 1'b0, 1'b1, 1'b1, "n1");  // 11 -> 10
    resolve(PcA, 1'b0, 1'b1, 1'b1, "n2");  // 10 -> 01
    resolve(PcA, 1'b0, 1'b0, 1'b0, "n3");  // 01 -> 00
    resolve(PcA, 1'b0, 1'b0, 1'b0, "n4");  // 00 -> 00
    resolve(PcA, 1'b1, 1'b0, 1'b1, "u1");  // 00 -> 01
    resolve(PcA, 1'b1, 1'b0, 1'b1, "u2");  // 01 -> 10
    resolve(PcA, 1'b1, 1'b1, 1'b0, "u3");  // 10 -> 11

    // Stall: branch held in E for 3 edges, single update when stallE falls.
    pcD = PcB; branchD = 1'b1;
    tick();
    stallE = 1'b1; actual_takeE = 1'b1;
    repeat (3) begin
      #1;
      check("stall.misp", {31'b0, mispredE}, 32'd1);
      check("stall.predD", {31'b0, pred_takeD}, 32'd0);
      tick();
    end
    stallE = 1'b0; branchD = 1'b0; #1;
    check("stall.fall.misp", {31'b0, mispredE}, 32'd1);
    tick();
    actual_takeE = 1'b0; pcD = PcB; branchD = 1'b1; #1;
    check("stall.after", {31'b0, pred_takeD}, 32'd1);
    resolve(PcB, 1'b0, 1'b1, 1'b1, "stall.n");
    pcD = PcB; branchD = 1'b1; #1;
    check("stall.once", {31'b0, pred_takeD}, 32'd0);

    // Flush of a D branch: E shows a bubble, nothing trained.
    pcD = PcC; branchD = 1'b1; flushE = 1'b1;
    tick();
    flushE = 1'b0; branchD = 1'b0; actual_takeE = 1'b1; #1;
    check("flush.predE", {31'b0, pred_takeE}, 32'd0);
    check("flush.misp", {31'b0, mispredE}, 32'd0);
    tick();
    actual_takeE = 1'b0; pcD = PcC; branchD = 1'b1; #1;
    check("flush.noupd", {31'b0, pred_takeD}, 32'd0);
    // Flush while a branch sits in E: it still trains.
    tick();
    branchD = 1'b0; flushE = 1'b1; actual_takeE = 1'b1; #1;
    check("flushupd.misp0", {31'b0, mispredE}, 32'd1);
    tick();
    flushE = 1'b0; #1;
    check("flushupd.predE", {31'b0, pred_takeE}, 32'd0);
    check("flushupd.misp", {31'b0, mispredE}, 32'd0);
    pcD = PcC; branchD = 1'b1; #1;
    check("flushupd.predD", {31'b0, pred_takeD}, 32'd1);
    branchD = 1'b0; actual_takeE = 1'b0;

    // Same-index collision: D sees pre-update value, then the new one.
    pcD = PcI5; branchD = 1'b1;
    tick();
    actual_takeE = 1'b1; #1;
    check("coll.now", {31'b0, pred_takeD}, 32'd0);
    tick();
    check("coll.next", {31'b0, pred_takeD}, 32'd1);
    branchD = 1'b0; actual_takeE = 1'b0;
    tick();
    tick();

    // Reset mid-operation discards the E branch and restores counters.
    pcD = PcA; branchD = 1'b1; #1;
    check("rst.pre", {31'b0, pred_takeD}, 32'd1);
    tick();
    resetn = 1'b0; branchD = 1'b0;
    tick();
    resetn = 1'b1; actual_takeE = 1'b1; #1;
    check("rst.predE", {31'b0, pred_takeE}, 32'd0);
    check("rst.misp", {31'b0, mispredE}, 32'd0);
    pcD = PcA; branchD = 1'b1; #1;
    check("rst.predD", {31'b0, pred_takeD}, 32'd0);
    branchD = 1'b0; actual_takeE = 1'b0;
`endif
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
